req_pending_bank: RTL

Pending-request register bank for the tracking engine channel scheduler. Each tracking channel raises a one-cycle request pulse. The block latches it into a pending bitmap, which the scheduler scans with its lowest-set-bit priority encoder. When the scheduler has serviced a channel, it returns the encoded bit position here. The block decodes that position back to a one-hot clear mask, tracks request overruns, and runs a stall watchdog.

---
 rtl/req_pending_bank_pkg.sv | 17 +
 rtl/req_pending_bank_pos_to_onehot.sv | 26 ++
 rtl/req_pending_bank.sv | 92 +++++++++
 3 files changed

// File: rtl/req_pending_bank_pkg.sv
// Shared tracking-engine definitions: default channel count and a
// constant-evaluable clog2 for sizing position and counter fields.
package req_pending_bank_pkg;

  localparam int CH_NUM_DEFAULT = 32;

  // Smallest r with (1 << r) >= value; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/req_pending_bank_pos_to_onehot.sv
// Decodes an LSB-first channel position into a one-hot mask; the inverse
// of the scheduler's lowest-set-bit priority encoder. Positions that do
// not name a channel produce an all-zero mask and raise out_of_range.
module pos_to_onehot
  import req_pending_bank_pkg::*;
#(
  parameter int  CH_NUM = CH_NUM_DEFAULT,
  localparam int POS_W  = clog2(CH_NUM)
) (
  input  logic              en,
  input  logic [POS_W-1:0]  pos,
  output logic [CH_NUM-1:0] onehot,
  output logic              out_of_range
);

  // Compare the position against every channel index; only an enabled,
  // in-range position can match.
  always_comb begin
    onehot       = '0;
    out_of_range = en && (32'(pos) >= 32'(CH_NUM));
    for (int i = 0; i < CH_NUM; i++) begin
      onehot[i] = en && (32'(pos) == 32'(i));
    end
  end

endmodule

// File: rtl/req_pending_bank.sv
// Pending-request bank for the channel scheduler: latches per-channel
// request pulses, retires serviced channels by position, records overruns
// and bad clears, and flags a stall when pending work is not serviced.
module req_pending_bank
  import req_pending_bank_pkg::*;
#(
  parameter int  CH_NUM       = CH_NUM_DEFAULT,
  parameter int  STALL_CYCLES = 1024,
  localparam int POS_W        = clog2(CH_NUM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH_NUM-1:0] set_req,
  input  logic [CH_NUM-1:0] req_mask,
  input  logic              clr_valid,
  input  logic [POS_W-1:0]  clr_pos,
  input  logic [CH_NUM-1:0] ovr_clr,
  input  logic              stall_clr,
  output logic [CH_NUM-1:0] pending,
  output logic              pending_any,
  output logic [CH_NUM-1:0] overrun,
  output logic              clr_err,
  output logic              stall
);

  localparam int              CNT_W     = clog2(STALL_CYCLES + 1);
  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_CYCLES);

  logic [CH_NUM-1:0] clr_onehot;
  logic              clr_oor;
  logic              valid_clr;
  logic [CH_NUM-1:0] eset;
  logic [CH_NUM-1:0] pending_q, pending_d;
  logic [CH_NUM-1:0] ovr_q, ovr_d;
  logic              clr_err_q, clr_err_d;
  logic              stall_q, stall_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  pos_to_onehot #(.CH_NUM(CH_NUM)) u_decode (
    .en           (clr_valid),
    .pos          (clr_pos),
    .onehot       (clr_onehot),
    .out_of_range (clr_oor)
  );

  assign eset      = set_req & req_mask;
  assign valid_clr = clr_valid & ~clr_oor;

  // Pending/overrun/error next state. A set landing on a bit being cleared
  // in the same cycle is a fresh request, so it is not an overrun.
  always_comb begin
    pending_d = eset | (pending_q & ~clr_onehot);
    ovr_d     = (ovr_q & ~ovr_clr) | (eset & pending_q & ~clr_onehot);
    clr_err_d = clr_err_q | (clr_valid & (clr_oor | ~(|(clr_onehot & pending_q))));
  end

  // Watchdog: counts cycles with work pending and no service, saturating;
  // stall_clr takes priority over a same-cycle reach.
  always_comb begin
    cnt_d = cnt_q;
    if (!pending_any || valid_clr || stall_clr) begin
      cnt_d = '0;
    end else if (cnt_q != STALL_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    stall_d = stall_clr ? 1'b0 : (stall_q | (cnt_d == STALL_MAX));
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      ovr_q     <= '0;
      clr_err_q <= 1'b0;
      stall_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      ovr_q     <= ovr_d;
      clr_err_q <= clr_err_d;
      stall_q   <= stall_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pending     = pending_q;
  assign pending_any = |pending_q;
  assign overrun     = ovr_q;
  assign clr_err     = clr_err_q;
  assign stall       = stall_q;

endmodule
